i2c_axi_master: RTL and testbench
=================================

I2C_AXI_MASTER -- requirements
Module: i2c_axi_master

Interface
REQ-001 Parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH, default 13, AXI4-Lite address width.
REQ-003 Port M_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-004 Port M_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-005 Ports M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1  write-address channel.
REQ-006 Ports M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1  write-data channel.
REQ-007 Ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1  write-response channel.
REQ-008 Ports M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1  read-address channel.
REQ-009 Ports M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1  read-data channel.
REQ-010 Ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in ADDR_W, cmd_wdata in 32, cmd_wstrb in 4  command request.
REQ-011 Ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_resp out 2, rsp_write out 1  command response.
REQ-012 Port busy  out 1  high whenever FSM not IDLE.

Function
REQ-013 FSM states: IDLE, WR (AW/W outstanding), WR_B, RD_A, RD_R, RSP; all outputs registered.
REQ-014 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid && cmd_ready; command fields latched that cycle.
REQ-015 Accepted write: next cycle AWVALID=1 and WVALID=1 together, AWADDR/WDATA/WSTRB from latched values; state WR.
REQ-016 In WR, AWVALID drops the cycle after AWVALID&&AWREADY, WVALID drops the cycle after WVALID&&WREADY, independently; either order or same cycle allowed.
REQ-017 Once both AW and W handshakes complete, go to WR_B with BREADY=1; never assert BREADY before both complete.
REQ-018 In WR_B, on BVALID&&BREADY: capture BRESP into rsp_resp, rsp_rdata=0, rsp_write=1, BREADY=0, go to RSP.
REQ-019 Accepted read: next cycle ARVALID=1 with latched address; state RD_A; ARVALID drops after ARVALID&&ARREADY; go to RD_R with RREADY=1.
REQ-020 In RD_R, on RVALID&&RREADY: capture RDATA, RRESP, rsp_write=0, RREADY=0, go to RSP.
REQ-021 In RSP, rsp_valid=1 with stable rsp_* until rsp_valid&&rsp_ready; then IDLE next cycle, cmd_ready=1.
REQ-022 VALID signals, once asserted, SHALL hold with stable address/data until handshake (AXI rule); never depend combinationally on READY.
REQ-023 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-024 Only one transaction outstanding; cmd_valid outside IDLE ignored; no timeout, waits indefinitely.
REQ-025 SLVERR/DECERR responses passed through unchanged in rsp_resp; no retry.
REQ-026 Minimum latency with slave readies high: cmd accept cycle N, AXI handshake N+1, B/R handshake N+2, rsp_valid N+3.

Reset
REQ-027 While M_AXI_ARESETN=0 at a clock edge: state IDLE; AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy = 0; cmd_ready = 0 during reset, 1 first cycle after.
REQ-028 rsp_rdata, rsp_resp, rsp_write, latched address/data/strobe reset to 0.
REQ-029 Reset mid-transaction SHALL abandon it immediately, no response issued; bench SHALL also reset the slave.

Verification
REQ-030 Write 0x1000 data 0xDEADBEEF strb 0xF, slave readies high -> AW/W both handshake N+1, BRESP=00 captured, rsp_valid at N+3, rsp_resp=00, rsp_write=1.
REQ-031 Read 0x1010, slave returns 0x000003A5 after 5-cycle RVALID delay -> ARVALID single handshake, rsp_rdata=0x000003A5, rsp_write=0.
REQ-032 Write with WREADY 4 cycles before AWREADY, then reverse order -> both VALIDs held until own handshake, BREADY only after both, one response each.
REQ-033 Slave returns BRESP=2'b10 -> rsp_resp=2'b10; rsp_ready held low 6 cycles -> rsp_* stable, cmd_ready=0 throughout.
REQ-034 ARESETN low during RD_R -> next cycle all VALID/READY outputs 0, rsp_valid=0; new write after reset completes normally.
REQ-035 Back-to-back cmd_valid held high with rsp_ready=1 -> second command accepted the cycle after RSP exit; no overlapping AXI transactions.

Source files
------------

// File: rtl/i2c_axi_master.sv
// Single-outstanding AXI4-Lite master: turns one command request into one AXI
// write (AW+W then B) or read (AR then R) and returns a registered response.
module i2c_axi_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 13
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_write,
  output logic                            busy
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

  state_t state_q, state_d;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;
  logic                          cmd_ready_q, cmd_ready_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          busy_q, busy_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;
  logic                          rsp_write_q, rsp_write_d;

  logic cmd_accept;
  assign cmd_accept = cmd_valid && cmd_ready_q;

  // State and every output are registered together; the *_d values below are
  // derived from the next state so each output is a flop, not a state decode.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_accept) state_d = cmd_write ? WR : RD_A;
      // A channel whose VALID has already dropped has completed its handshake.
      WR:   if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) state_d = WR_B;
      WR_B: if (M_AXI_BVALID && bready_q) state_d = RSP;
      RD_A: if (M_AXI_ARREADY) state_d = RD_R;
      RD_R: if (M_AXI_RVALID && rready_q) state_d = RSP;
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    case (state_q)
      IDLE: if (cmd_accept) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        awvalid_d = cmd_write;
        wvalid_d  = cmd_write;
        arvalid_d = !cmd_write;
      end
      WR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
      end
      RD_A: if (M_AXI_ARREADY) arvalid_d = 1'b0;
      WR_B: if (M_AXI_BVALID && bready_q) begin
        rsp_rdata_d = '0;
        rsp_resp_d  = M_AXI_BRESP;
        rsp_write_d = 1'b1;
      end
      RD_R: if (M_AXI_RVALID && rready_q) begin
        rsp_rdata_d = M_AXI_RDATA;
        rsp_resp_d  = M_AXI_RRESP;
        rsp_write_d = 1'b0;
      end
      default: ;
    endcase
    bready_d    = (state_d == WR_B);
    rready_d    = (state_d == RD_R);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    busy_d      = (state_d != IDLE);
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_write     = rsp_write_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_axi_master.sv
// Bench for i2c_axi_master: delay-programmable AXI4-Lite memory slave with a
// protocol monitor, plus a word-array model that predicts every response.
module tb_i2c_axi_master;

  logic        clk;
  logic        M_AXI_ARESETN;
  logic [12:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [12:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = 32'h0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write, busy;

  i2c_axi_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(13)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(M_AXI_ARESETN),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned passed = 0, total = 0;
  int cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] smem [0:2047];
  logic [31:0] model_mem [0:2047];

  // slave / monitor state
  int  aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, viol = 0;
  int  aw_c, w_c, b_c, ar_c, r_c;
  logic aw_p, w_p, b_p, ar_p, r_p, aw_got, w_got, ar_got;
  logic prev_awv, prev_wv, prev_arv;
  logic [12:0] prev_awaddr, prev_araddr, s_awaddr, s_araddr;
  logic [31:0] prev_wdata, s_wdata;
  logic [3:0]  prev_wstrb, s_wstrb;

  // expectations for the transaction in flight
  int exp_off, acc_cyc, base_aw, base_w, base_b, base_ar, base_r;
  logic        exp_wr;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;
  logic [19:0] exp_counts;

  // Slave acts 1 time unit after each edge; handshakes seen now complete at
  // the next edge and are applied on the following pass.
  always begin
    @(posedge clk); #1;
    if (!M_AXI_ARESETN) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      aw_p = 1'b0; w_p = 1'b0; b_p = 1'b0; ar_p = 1'b0; r_p = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      prev_awv = 1'b0; prev_wv = 1'b0; prev_arv = 1'b0;
      prev_awaddr = '0; prev_araddr = '0; prev_wdata = '0; prev_wstrb = '0;
    end else begin
      if (prev_awv && !aw_p && (!M_AXI_AWVALID || M_AXI_AWADDR !== prev_awaddr)) viol++;
      if (prev_wv && !w_p && (!M_AXI_WVALID || M_AXI_WDATA !== prev_wdata ||
                              M_AXI_WSTRB !== prev_wstrb)) viol++;
      if (prev_arv && !ar_p && (!M_AXI_ARVALID || M_AXI_ARADDR !== prev_araddr)) viol++;
      if (aw_p) begin aw_got = 1'b1; s_awaddr = prev_awaddr; M_AXI_AWREADY = 1'b0; aw_c = 0; aw_n++; end
      if (w_p)  begin w_got = 1'b1; s_wdata = prev_wdata; s_wstrb = prev_wstrb; M_AXI_WREADY = 1'b0; w_c = 0; w_n++; end
      if (ar_p) begin ar_got = 1'b1; s_araddr = prev_araddr; M_AXI_ARREADY = 1'b0; ar_c = 0; r_c = 0; ar_n++; end
      if (b_p) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) smem[s_awaddr[12:2]][8*i +: 8] = s_wdata[8*i +: 8];
        M_AXI_BVALID = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_c = 0; b_n++;
      end
      if (r_p) begin M_AXI_RVALID = 1'b0; ar_got = 1'b0; r_c = 0; r_n++; end
      if (M_AXI_AWVALID && !aw_got) begin if (aw_c >= cfg_aw) M_AXI_AWREADY = 1'b1; else aw_c++; end
      if (M_AXI_WVALID && !w_got)   begin if (w_c >= cfg_w) M_AXI_WREADY = 1'b1; else w_c++; end
      if (M_AXI_ARVALID && !ar_got) begin if (ar_c >= cfg_ar) M_AXI_ARREADY = 1'b1; else ar_c++; end
      if (aw_got && w_got && !M_AXI_BVALID) begin
        if (b_c >= cfg_b) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = cfg_bresp; end else b_c++;
      end
      if (ar_got && !M_AXI_RVALID) begin
        if (r_c >= cfg_r) begin
          M_AXI_RVALID = 1'b1; M_AXI_RDATA = smem[s_araddr[12:2]]; M_AXI_RRESP = cfg_rresp;
        end else r_c++;
      end
      if (M_AXI_BREADY && !(aw_got && w_got)) viol++;
      if (M_AXI_RREADY && !ar_got) viol++;
      if ((M_AXI_AWVALID || M_AXI_WVALID || aw_got || w_got) && (M_AXI_ARVALID || ar_got)) viol++;
      if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) viol++;
      aw_p = M_AXI_AWVALID && M_AXI_AWREADY;
      w_p  = M_AXI_WVALID && M_AXI_WREADY;
      ar_p = M_AXI_ARVALID && M_AXI_ARREADY;
      b_p  = M_AXI_BVALID && M_AXI_BREADY;
      r_p  = M_AXI_RVALID && M_AXI_RREADY;
      prev_awv = M_AXI_AWVALID; prev_awaddr = M_AXI_AWADDR;
      prev_wv = M_AXI_WVALID; prev_wdata = M_AXI_WDATA; prev_wstrb = M_AXI_WSTRB;
      prev_arv = M_AXI_ARVALID; prev_araddr = M_AXI_ARADDR;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic wr, input logic [12:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic keep, output int waited);
    int idx;
    idx = int'(addr[12:2]);
    base_aw = aw_n; base_w = w_n; base_b = b_n; base_ar = ar_n; base_r = r_n;
    exp_wr = wr;
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) model_mem[idx][8*i +: 8] = data[8*i +: 8];
      exp_rdata = '0;
      exp_resp = cfg_bresp;
      exp_off = 3 + ((cfg_aw > cfg_w) ? cfg_aw : cfg_w) + cfg_b;
      exp_counts = 20'h11100;
    end else begin
      exp_rdata = model_mem[idx];
      exp_resp = cfg_rresp;
      exp_off = 3 + cfg_ar + cfg_r;
      exp_counts = 20'h00011;
    end
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin tick(); waited++; end
    check("accept_timeout", 64'(waited < 50), 64'(1));
    tick();
    acc_cyc = cyc;
    if (!keep) cmd_valid = 1'b0;
    check("post_accept_ctrl", 64'({cmd_ready, busy}), 64'(2'b01));
    if (wr) begin
      check("wr_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 64'(3'b110));
      check("wr_fields", 64'({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}), 64'({addr, data, strb}));
    end else begin
      check("rd_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 64'(3'b001));
      check("rd_addr", 64'(M_AXI_ARADDR), 64'(addr));
    end
  endtask

  task automatic expect_rsp(input int hold);
    int n;
    n = 0;
    rsp_ready = (hold == 0);
    while (!rsp_valid && n < 300) begin tick(); n++; end
    check("rsp_timeout", 64'(n < 300), 64'(1));
    check("rsp_latency", 64'(cyc - acc_cyc + 1), 64'(exp_off));
    check("rsp_fields", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({exp_wr, exp_resp, exp_rdata}));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rsp_hold", 64'({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}),
            64'({1'b1, 1'b0, exp_wr, exp_resp, exp_rdata}));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle_after_rsp", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
    check("axi_handshakes", 64'({4'(aw_n - base_aw), 4'(w_n - base_w), 4'(b_n - base_b),
                                 4'(ar_n - base_ar), 4'(r_n - base_r)}), 64'(exp_counts));
    check("protocol", 64'(viol), 64'(0));
  endtask

  initial begin
    int wt;
    M_AXI_ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    for (int i = 0; i < 2048; i++) begin smem[i] = '0; model_mem[i] = '0; end

    repeat (3) tick();
    check("rst_ctrl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                           M_AXI_RREADY, rsp_valid, busy, cmd_ready}), 64'(0));
    check("rst_data", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
    check("rst_latch", 64'({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}), 64'(0));
    M_AXI_ARESETN = 1'b1;
    tick();
    check("ready_after_rst", 64'({cmd_ready, busy}), 64'(2'b10));

    // write with zero-delay slave: minimum latency
    send(1'b1, 13'h1000, 32'hDEADBEEF, 4'hF, 1'b0, wt);
    expect_rsp(0);

    // read with late RVALID
    smem[13'h1010 >> 2] = 32'h000003A5;
    model_mem[13'h1010 >> 2] = 32'h000003A5;
    cfg_r = 5;
    send(1'b0, 13'h1010, 32'h0, 4'h0, 1'b0, wt);
    expect_rsp(0);
    cfg_r = 0;

    // W accepted well before AW, then the reverse
    cfg_aw = 4; cfg_w = 0;
    send(1'b1, 13'h1020, 32'h11223344, 4'hF, 1'b0, wt);
    expect_rsp(0);
    cfg_aw = 0; cfg_w = 4;
    send(1'b1, 13'h1024, 32'h55667788, 4'h5, 1'b0, wt);
    expect_rsp(0);
    cfg_w = 0;
    send(1'b0, 13'h1024, 32'h0, 4'h0, 1'b0, wt);
    expect_rsp(0);

    // error responses pass through; response stalled by rsp_ready
    cfg_bresp = 2'b10;
    send(1'b1, 13'h1030, 32'hCAFEF00D, 4'hC, 1'b0, wt);
    expect_rsp(6);
    cfg_bresp = 2'b00; cfg_rresp = 2'b11;
    send(1'b0, 13'h1030, 32'h0, 4'h0, 1'b0, wt);
    expect_rsp(2);
    cfg_rresp = 2'b00;

    // reset while waiting for R
    cfg_r = 20;
    send(1'b0, 13'h1000, 32'h0, 4'h0, 1'b0, wt);
    wt = 0;
    while (!M_AXI_RREADY && wt < 20) begin tick(); wt++; end
    check("reached_rd_r", 64'(M_AXI_RREADY), 64'(1));
    M_AXI_ARESETN = 1'b0;
    tick();
    check("mid_rst_ctrl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                               M_AXI_RREADY, rsp_valid, busy, cmd_ready}), 64'(0));
    M_AXI_ARESETN = 1'b1;
    cfg_r = 0;
    tick();
    check("post_rst_ctrl", 64'({rsp_valid, busy, cmd_ready}), 64'(3'b001));
    check("post_rst_data", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
    send(1'b1, 13'h1050, 32'hA5A55A5A, 4'hF, 1'b0, wt);
    expect_rsp(0);

    // cmd_valid held across a whole transaction, next command queued behind it
    send(1'b1, 13'h1040, 32'h0BADC0DE, 4'hF, 1'b1, wt);
    cmd_write = 1'b0; cmd_addr = 13'h1040;
    expect_rsp(0);
    send(1'b0, 13'h1040, 32'h0, 4'h0, 1'b0, wt);
    check("back_to_back_wait", 64'(wt), 64'(0));
    expect_rsp(0);

    // randomized traffic over a small address window
    for (int k = 0; k < 24; k++) begin
      logic        rw;
      logic [12:0] ra;
      rw = 1'($urandom_range(0, 1));
      ra = 13'(32'h0100 + ($urandom_range(0, 7) << 2));
      cfg_aw = int'($urandom_range(0, 3)); cfg_w = int'($urandom_range(0, 3));
      cfg_b = int'($urandom_range(0, 3)); cfg_ar = int'($urandom_range(0, 3));
      cfg_r = int'($urandom_range(0, 3));
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      send(rw, ra, $urandom, 4'($urandom_range(0, 15)), 1'b0, wt);
      expect_rsp(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
